// File: rtl/lab62soc_timer_sequencer_if.sv
// Timer s1 slave bus between the sequencer (master) and the interval timer
// (slave). The sequencer only writes; the timer drives its interrupt back.
//   tm_address     4   register select
//   tm_chipselect  1   access strobe
//   tm_write_n     1   write strobe, active low
//   tm_writedata   16  write data
//   tm_irq         1   timer interrupt (timeout && ITO)
interface lab62soc_timer_sequencer_if;
    logic [3:0]  tm_address;
    logic        tm_chipselect;
    logic        tm_write_n;
    logic [15:0] tm_writedata;
    logic        tm_irq;

    modport master (
        output tm_address,
        output tm_chipselect,
        output tm_write_n,
        output tm_writedata,
        input  tm_irq
    );

    modport slave (
        input  tm_address,
        input  tm_chipselect,
        input  tm_write_n,
        input  tm_writedata,
        output tm_irq
    );
endinterface

// File: rtl/lab62soc_timer_sequencer.sv
// Shares one interval timer among NUM_REQ requesters. Round-robin picks an
// owner, programs a one-shot delay of req_len cycles, waits for the timer irq
// (or an owner cancel), clears the timer status and pulses done/aborted.
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   req, req_len      level requests and per-requester delay (slice i)
//   cancel            per-requester abort, honoured only for the owner in WAIT
//   grant             one-hot owner, 0 when idle
//   done, aborted     1-cycle pulse to the owner
//   busy              high outside IDLE
//   tm                timer s1 master port
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | no owner; arbitrate among req
// WR_P0..P3 | write period halfwords (addr 2..5)
// GAP       | no access, lets the timer reload settle
// WR_CTRL   | write START|ITO one-shot (addr 1)
// WAIT      | wait for irq or owner cancel
// STOP      | write STOP (addr 1)
// CLR_D/A   | clear timer status (addr 0) before done/abort
// DONE      | done pulse to owner
// ABORT     | aborted pulse to owner
module lab62soc_timer_sequencer #(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]       cancel,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       aborted,
    output logic                     busy,
    lab62soc_timer_sequencer_if.master tm
);
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_P0, S_WR_P1, S_WR_P2, S_WR_P3, S_GAP, S_WR_CTRL,
        S_WAIT, S_STOP, S_CLR_D, S_CLR_A, S_DONE, S_ABORT
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;
    logic               pick_valid;
    logic [LEN_W-1:0]   pick_len;
    logic [31:0]        len_m1;
    logic               cancel_own;

    logic [3:0]         tm_addr;
    logic               tm_cs;
    logic               tm_wn;
    logic [15:0]        tm_data;

    // First set request strictly after the rr pointer, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_len = req_len[int'(pick_idx)*LEN_W +: LEN_W];
    end

    assign cancel_own = |(cancel & grant);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            rr_ptr <= PTR_W'(NUM_REQ - 1);
            grant  <= '0;
            len_m1 <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pick_valid) begin
                grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                rr_ptr <= pick_idx;
                // Timer counts period+1 cycles, so program len-1.
                len_m1 <= 32'(pick_len - LEN_W'(1));
            end else if (state == S_DONE || state == S_ABORT) begin
                grant <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tm_addr   = 4'd0;
        tm_cs     = 1'b0;
        tm_wn     = 1'b1;
        tm_data   = 16'h0000;
        done      = '0;
        aborted   = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (pick_valid)
                    state_nxt = (pick_len == '0) ? S_DONE : S_WR_P0;
            end
            S_WR_P0: begin
                tm_cs = 1'b1; tm_wn = 1'b0; tm_addr = 4'd2; tm_data = len_m1[15:0];
                state_nxt = S_WR_P1;
            end
            S_WR_P1: begin
                tm_cs = 1'b1; tm_wn = 1'b0; tm_addr = 4'd3; tm_data = len_m1[31:16];
                state_nxt = S_WR_P2;
            end
            S_WR_P2: begin
                tm_cs = 1'b1; tm_wn = 1'b0; tm_addr = 4'd4;
                state_nxt = S_WR_P3;
            end
            S_WR_P3: begin
                tm_cs = 1'b1; tm_wn = 1'b0; tm_addr = 4'd5;
                state_nxt = S_GAP;
            end
            S_GAP: state_nxt = S_WR_CTRL;
            S_WR_CTRL: begin
                tm_cs = 1'b1; tm_wn = 1'b0; tm_addr = 4'd1; tm_data = 16'h0005;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tm.tm_irq)
                    state_nxt = S_CLR_D;
                else if (cancel_own)
                    state_nxt = S_STOP;
            end
            S_STOP: begin
                tm_cs = 1'b1; tm_wn = 1'b0; tm_addr = 4'd1; tm_data = 16'h0008;
                state_nxt = S_CLR_A;
            end
            S_CLR_D: begin
                tm_cs = 1'b1; tm_wn = 1'b0;
                state_nxt = S_DONE;
            end
            S_CLR_A: begin
                tm_cs = 1'b1; tm_wn = 1'b0;
                state_nxt = S_ABORT;
            end
            S_DONE: begin
                done      = grant;
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                aborted   = grant;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign tm.tm_address    = tm_addr;
    assign tm.tm_chipselect = tm_cs;
    assign tm.tm_write_n    = tm_wn;
    assign tm.tm_writedata  = tm_data;
endmodule

// File: tb/tb_lab62soc_timer_sequencer.sv
// Bench for lab62soc_timer_sequencer: directed vector table, hand-written
// corner sequences, then random traffic checked against a transaction-level
// reference model. A small behavioural interval timer answers the s1 bus.
module tb_lab62soc_timer_sequencer;
    localparam int NUM_REQ = 2;
    localparam int LEN_W   = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, cancel, grant, done, aborted;
    logic [63:0] req_len;
    logic        busy;

    lab62soc_timer_sequencer_if tm_bus();

    lab62soc_timer_sequencer #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_len(req_len), .cancel(cancel),
        .grant(grant), .done(done), .aborted(aborted), .busy(busy), .tm(tm_bus)
    );

    always #5 clk = ~clk;

    // Behavioural timer: one-shot, expires req_len edges after the START write.
    logic [31:0] t_period, t_cnt;
    logic        t_run, t_to, t_ito;
    always @(posedge clk) begin
        if (!reset_n) begin
            t_period <= '0; t_cnt <= '0; t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
        end else if (tm_bus.tm_chipselect && !tm_bus.tm_write_n) begin
            case (tm_bus.tm_address)
                4'd0: t_to <= 1'b0;
                4'd1: begin
                    t_ito <= tm_bus.tm_writedata[0];
                    if (tm_bus.tm_writedata[3]) t_run <= 1'b0;
                    else if (tm_bus.tm_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                end
                4'd2: t_period[15:0]  <= tm_bus.tm_writedata;
                4'd3: t_period[31:16] <= tm_bus.tm_writedata;
                default: ;
            endcase
        end else if (t_run) begin
            if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
            else t_cnt <= t_cnt - 1;
        end
    end
    assign tm_bus.tm_irq = t_to & t_ito;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] len0;
        logic [31:0] len1;
        logic [1:0]  cancel_mask;
        int          cancel_at;
        logic [1:0]  exp_grant;
        bit          exp_done;
        logic [15:0] exp_hw0;
        logic [15:0] exp_hw1;
        int          exp_cs;
    } vec_t;

    vec_t vecs[10];

    task automatic run_txn(input vec_t v, input int n);
        int waits, t, ctrl_t, done_t, cs_cnt;
        logic [15:0] hw0, hw1;
        logic got_done, got_abort, ok;
        logic [31:0] olen;
        string tag;
        tag = $sformatf("vec%0d", n);
        req = v.req; req_len = {v.len1, v.len0}; cancel = 2'b00;
        waits = 0; ok = 1'b0;
        while (waits < 20 && !ok) begin
            tick(); waits++;
            ok = (grant != 2'b00);
        end
        check({tag, "_grant_wait"}, waits, 1);
        check({tag, "_grant"}, grant, v.exp_grant);
        olen = (v.exp_grant == 2'b10) ? v.len1 : v.len0;
        t = 0; ctrl_t = -1; done_t = -1; cs_cnt = 0; hw0 = 16'hxxxx; hw1 = 16'hxxxx;
        got_done = 1'b0; got_abort = 1'b0;
        forever begin
            if (tm_bus.tm_chipselect) cs_cnt++;
            if (tm_bus.tm_chipselect && !tm_bus.tm_write_n) begin
                if (tm_bus.tm_address == 4'd2) hw0 = tm_bus.tm_writedata;
                if (tm_bus.tm_address == 4'd3) hw1 = tm_bus.tm_writedata;
                if (tm_bus.tm_address == 4'd1 && tm_bus.tm_writedata == 16'h0005) ctrl_t = t;
            end
            if (done != 2'b00 || aborted != 2'b00) begin
                got_done = (done != 2'b00); got_abort = (aborted != 2'b00); done_t = t;
                check({tag, "_pulse_owner"}, done | aborted, v.exp_grant);
                break;
            end
            t++;
            if (t > 1500) begin
                check({tag, "_end_timeout"}, t, 0);
                break;
            end
            cancel = (v.cancel_at >= 0 && t >= v.cancel_at) ? v.cancel_mask : 2'b00;
            tick();
        end
        req = 2'b00; cancel = 2'b00;
        check({tag, "_done"}, got_done, v.exp_done);
        check({tag, "_aborted"}, got_abort, !v.exp_done);
        check({tag, "_cs_cycles"}, cs_cnt, v.exp_cs);
        if (v.exp_cs != 0) begin
            check({tag, "_hw0"}, hw0, v.exp_hw0);
            check({tag, "_hw1"}, hw1, v.exp_hw1);
            check({tag, "_ctrl_cycle"}, ctrl_t, 5);
        end
        if (v.exp_done && olen == 0) check({tag, "_done_lat0"}, done_t, 0);
        if (v.exp_done && olen != 0) check({tag, "_done_lat"}, done_t - ctrl_t, olen + 3);
        tick();
        check({tag, "_after_idle"}, {done, aborted, grant, busy}, 7'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; cancel = '0; req_len = '0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    // Reference-model state for the random phase.
    int            mptr, owner, t_m, ctrl_m, pred;
    logic [31:0]   olen_m;
    bit            in_txn;
    logic [1:0]    prev_req;
    logic [31:0]   prev_len [2];
    logic [31:0]   cur_len  [2];
    logic [19:0]   wq[$];
    logic [19:0]   eq[$];

    initial begin
        int waits, c;
        logic ok, seen_done, seen_abort, seen_stop;
        logic [1:0] exp_g, pulse;
        logic [31:0] lm;

        vecs[0] = '{2'b01, 32'd100,         32'd0,         2'b00, -1, 2'b01, 1'b1, 16'h0063, 16'h0000, 6};
        vecs[1] = '{2'b10, 32'd0,           32'd5,         2'b00, -1, 2'b10, 1'b1, 16'h0004, 16'h0000, 6};
        vecs[2] = '{2'b01, 32'd0,           32'd0,         2'b00, -1, 2'b01, 1'b1, 16'h0000, 16'h0000, 0};
        vecs[3] = '{2'b01, 32'd1000,        32'd0,         2'b01, 56, 2'b01, 1'b0, 16'h03E7, 16'h0000, 7};
        vecs[4] = '{2'b10, 32'd0,           32'h0001_0000, 2'b10, 20, 2'b10, 1'b0, 16'hFFFF, 16'h0000, 7};
        vecs[5] = '{2'b01, 32'h0002_0000,   32'd0,         2'b01,  2, 2'b01, 1'b0, 16'hFFFF, 16'h0001, 7};
        vecs[6] = '{2'b11, 32'd3,           32'd7,         2'b00, -1, 2'b10, 1'b1, 16'h0006, 16'h0000, 6};
        vecs[7] = '{2'b11, 32'd3,           32'd7,         2'b00, -1, 2'b01, 1'b1, 16'h0002, 16'h0000, 6};
        vecs[8] = '{2'b01, 32'd30,          32'd0,         2'b10,  8, 2'b01, 1'b1, 16'h001D, 16'h0000, 6};
        vecs[9] = '{2'b10, 32'd0,           32'd1,         2'b00, -1, 2'b10, 1'b1, 16'h0000, 16'h0000, 6};

        reset_n = 1'b0; req = '0; cancel = '0; req_len = '0;
        tick();
        check("reset_outputs", {grant, done, aborted, busy, tm_bus.tm_chipselect}, 8'd0);
        check("reset_bus", {tm_bus.tm_write_n, tm_bus.tm_address, tm_bus.tm_writedata}, {1'b1, 4'd0, 16'd0});
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Held req=11: grants must alternate starting with requester 0.
        req = 2'b11; req_len = {32'd10, 32'd10};
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            waits = 0; ok = 1'b0;
            while (waits < 10 && !ok) begin tick(); waits++; ok = (grant != 2'b00); end
            check($sformatf("alt%0d_grant", n), grant, exp_g);
            waits = 0; ok = 1'b0;
            while (waits < 100 && !ok) begin tick(); waits++; ok = (done != 2'b00); end
            check($sformatf("alt%0d_done", n), done, exp_g);
        end
        req = 2'b00;
        tick(); tick();

        // irq and owner cancel in the same WAIT cycle: irq wins.
        req = 2'b01; req_len = {32'd0, 32'd20};
        waits = 0; ok = 1'b0;
        while (waits < 100 && !ok) begin tick(); waits++; ok = tm_bus.tm_irq; end
        check("race_irq_seen", ok, 1'b1);
        cancel = 2'b01;
        seen_done = 1'b0; seen_abort = 1'b0; seen_stop = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            cancel = 2'b00;
            if (done[0]) seen_done = 1'b1;
            if (aborted != 2'b00) seen_abort = 1'b1;
            if (tm_bus.tm_chipselect && tm_bus.tm_address == 4'd1 && tm_bus.tm_writedata == 16'h0008)
                seen_stop = 1'b1;
            if (done[0]) req = 2'b00;
        end
        check("race_done", seen_done, 1'b1);
        check("race_aborted", seen_abort, 1'b0);
        check("race_stop_write", seen_stop, 1'b0);
        req = 2'b00;
        tick(); tick();

        // Reset while waiting, then a fresh request is served from reset pointer.
        req = 2'b10; req_len = {32'd1000, 32'd0};
        repeat (20) tick();
        check("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0; req = 2'b11; req_len = {32'd5, 32'd5};
        tick();
        check("midreset_outputs", {grant, done, aborted, busy, tm_bus.tm_chipselect}, 8'd0);
        check("midreset_bus", {tm_bus.tm_write_n, tm_bus.tm_address, tm_bus.tm_writedata}, {1'b1, 4'd0, 16'd0});
        reset_n = 1'b1;
        waits = 0; ok = 1'b0;
        while (waits < 10 && !ok) begin tick(); waits++; ok = (grant != 2'b00); end
        check("postreset_grant", grant, 2'b01);
        waits = 0; ok = 1'b0;
        while (waits < 100 && !ok) begin tick(); waits++; ok = (done != 2'b00); end
        check("postreset_done", done, 2'b01);
        req = 2'b00;

        // Random traffic against a transaction-level model.
        do_reset();
        mptr = NUM_REQ - 1; in_txn = 0; prev_req = 2'b00;
        prev_len[0] = 0; prev_len[1] = 0; cur_len[0] = 0; cur_len[1] = 0;
        for (int k = 0; k < 5000; k++) begin
            tick();
            check("busy_vs_grant", busy, grant != 2'b00);
            if (!in_txn && grant != 2'b00) begin
                exp_g = 2'b00; owner = -1;
                for (int i = 1; i <= NUM_REQ; i++) begin
                    c = (mptr + i) % NUM_REQ;
                    if (owner < 0 && prev_req[c]) owner = c;
                end
                if (owner >= 0) begin exp_g = 2'b01 << owner; mptr = owner; end
                check("rr_grant", grant, exp_g);
                if (owner < 0) owner = grant[1] ? 1 : 0;
                in_txn = 1; t_m = 0; ctrl_m = -1; pred = 0; wq.delete();
                olen_m = prev_len[owner];
            end else if (in_txn) begin
                t_m++;
            end
            if (in_txn && tm_bus.tm_chipselect && !tm_bus.tm_write_n) begin
                wq.push_back({tm_bus.tm_address, tm_bus.tm_writedata});
                if (tm_bus.tm_address == 4'd1 && tm_bus.tm_writedata == 16'h0005) ctrl_m = t_m;
            end
            pulse = done | aborted;
            if (pulse != 2'b00) begin
                if (!in_txn) begin
                    check("pulse_without_grant", pulse, 2'b00);
                end else begin
                    check("rnd_pulse_owner", pulse, 2'b01 << owner);
                    if (olen_m == 0) pred = 1;
                    check("rnd_outcome_resolved", pred != 0, 1'b1);
                    check("rnd_done", done != 2'b00, pred == 1);
                    eq.delete();
                    if (olen_m != 0) begin
                        lm = olen_m - 1;
                        eq.push_back({4'd2, lm[15:0]});
                        eq.push_back({4'd3, lm[31:16]});
                        eq.push_back({4'd4, 16'h0000});
                        eq.push_back({4'd5, 16'h0000});
                        eq.push_back({4'd1, 16'h0005});
                        if (pred == 2) eq.push_back({4'd1, 16'h0008});
                        eq.push_back({4'd0, 16'h0000});
                    end
                    ok = (wq.size() == eq.size());
                    if (ok) foreach (eq[i]) if (wq[i] !== eq[i]) ok = 1'b0;
                    check("rnd_write_seq", ok, 1'b1);
                    if (done != 2'b00 && olen_m != 0) check("rnd_done_lat", t_m - ctrl_m, olen_m + 3);
                    in_txn = 0;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pulse[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else cur_len[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    cur_len[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
                end
                cancel[i] = ($urandom_range(0, 23) == 0);
            end
            req_len = {cur_len[1], cur_len[0]};
            if (in_txn && olen_m != 0 && ctrl_m >= 0 && t_m > ctrl_m && pred == 0) begin
                if (tm_bus.tm_irq) pred = 1;
                else if (cancel[owner]) pred = 2;
            end
            prev_req = req;
            prev_len[0] = cur_len[0]; prev_len[1] = cur_len[1];
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
